// File: rtl/icn_pkg.sv
// Shared definitions for the MVU interconnect transmit engine.
package icn_pkg;

   localparam int N_DEF     = 8;
   localparam int W_DEF     = 64;
   localparam int BADDR_DEF = 15;
   localparam int RDLAT_DEF = 2;
   localparam int RDLAT_MIN = 1;
   localparam int RDLAT_MAX = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } tx_state_e;

   // Two slots beyond the read latency let the FIFO sustain one word per cycle.
   function automatic int fifo_depth(input int rdlat);
      int lat;
      lat = (rdlat < RDLAT_MIN) ? RDLAT_MIN : ((rdlat > RDLAT_MAX) ? RDLAT_MAX : rdlat);
      return lat + 2;
   endfunction

   localparam int FIFO_DEPTH = fifo_depth(RDLAT_DEF);

endpackage

// File: rtl/icn_tx_fifo.sv
// Small synchronous FIFO holding words returned from local memory until granted.
module icn_tx_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= (wr_q == LAST) ? '0 : wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= (rd_q == LAST) ? '0 : rd_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/icn_tx.sv
// Per-MVU transmit engine: reads a block from local memory and streams it to
// the crossbar under per-cycle arbiter grant, with credit-limited read issue.
module icn_tx
   import icn_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int W     = W_DEF,
   parameter int BADDR = BADDR_DEF,
   parameter int RDLAT = RDLAT_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [N-1:0]     cmd_dest,
   input  logic [BADDR-1:0] cmd_src_addr,
   input  logic [BADDR-1:0] cmd_dst_addr,
   input  logic [BADDR-1:0] cmd_len,
   output logic             mem_rd_en,
   output logic [BADDR-1:0] mem_rd_addr,
   input  logic [W-1:0]     mem_rd_word,
   input  logic             tx_grant,
   output logic [N-1:0]     send_to,
   output logic             send_en,
   output logic [BADDR-1:0] send_addr,
   output logic [W-1:0]     send_word,
   output logic             busy,
   output logic             done
);

   localparam int DEPTH = fifo_depth(RDLAT);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int OW    = $clog2(DEPTH + RDLAT + 1);

   tx_state_e        state_q;
   logic [N-1:0]     dest_q;
   logic [BADDR-1:0] src_q;
   logic [BADDR-1:0] dst_q;
   logic [BADDR-1:0] reads_left_q;
   logic [BADDR-1:0] issued_q;
   logic [BADDR-1:0] sent_q;
   logic [BADDR-1:0] pops_left_q;
   logic [RDLAT-1:0] vld_q;
   logic [N-1:0]     send_to_q;
   logic             send_en_q;
   logic [BADDR-1:0] send_addr_q;
   logic [W-1:0]     send_word_q;
   logic             done_q;

   logic [CW-1:0]    fifo_count;
   logic [W-1:0]     fifo_head;
   logic [OW-1:0]    outstanding;
   logic             rd_en;
   logic             push;
   logic             pop;

   // Credits: words already buffered plus reads still travelling back.
   always_comb begin
      outstanding = OW'(fifo_count);
      for (int i = 0; i < RDLAT; i++) begin
         outstanding = outstanding + OW'(vld_q[i]);
      end
   end

   assign rd_en = (state_q == RUN) && (reads_left_q != '0) && (outstanding < OW'(DEPTH));
   assign push  = vld_q[RDLAT-1];
   assign pop   = (state_q == RUN) && (fifo_count != '0) && tx_grant;

   generate
      if (RDLAT == 1) begin : g_vld_one
         always_ff @(posedge clk or posedge clr) begin
            if (clr) vld_q <= '0;
            else     vld_q <= rd_en;
         end
      end else begin : g_vld_multi
         always_ff @(posedge clk or posedge clr) begin
            if (clr) vld_q <= '0;
            else     vld_q <= {vld_q[RDLAT-2:0], rd_en};
         end
      end
   endgenerate

   icn_tx_fifo #(
      .W     (W),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .clr     (clr),
      .push_i  (push),
      .wdata_i (mem_rd_word),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= IDLE;
         dest_q       <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         reads_left_q <= '0;
         issued_q     <= '0;
         sent_q       <= '0;
         pops_left_q  <= '0;
         send_to_q    <= '0;
         send_en_q    <= 1'b0;
         send_addr_q  <= '0;
         send_word_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         send_en_q   <= pop;
         send_to_q   <= pop ? dest_q : '0;
         send_addr_q <= pop ? dst_q + sent_q : '0;
         send_word_q <= pop ? fifo_head : '0;
         if (rd_en) begin
            reads_left_q <= reads_left_q - BADDR'(1);
            issued_q     <= issued_q + BADDR'(1);
         end
         if (pop) begin
            sent_q      <= sent_q + BADDR'(1);
            pops_left_q <= pops_left_q - BADDR'(1);
         end
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  dest_q       <= cmd_dest;
                  src_q        <= cmd_src_addr;
                  dst_q        <= cmd_dst_addr;
                  reads_left_q <= cmd_len;
                  pops_left_q  <= cmd_len;
                  issued_q     <= '0;
                  sent_q       <= '0;
                  if (cmd_len == '0) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               // done lines up with the final send_en, one cycle after the last pop
               if (pop && (pops_left_q == BADDR'(1))) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign mem_rd_en   = rd_en;
   assign mem_rd_addr = src_q + issued_q;
   assign send_to     = send_to_q;
   assign send_en     = send_en_q;
   assign send_addr   = send_addr_q;
   assign send_word   = send_word_q;
   assign done        = done_q;

endmodule

// File: tb/tb_icn_tx.sv
// Self-checking bench for icn_tx: directed table, stall/reset sequences and random transfers.
module tb_icn_tx;
   import icn_pkg::*;

   localparam int N     = 8;
   localparam int W     = 64;
   localparam int BADDR = 15;
   localparam int RDLAT = 2;
   localparam int DEPTH = FIFO_DEPTH;

   logic             clk;
   logic             clr;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [N-1:0]     cmd_dest;
   logic [BADDR-1:0] cmd_src_addr;
   logic [BADDR-1:0] cmd_dst_addr;
   logic [BADDR-1:0] cmd_len;
   logic             mem_rd_en;
   logic [BADDR-1:0] mem_rd_addr;
   logic [W-1:0]     mem_rd_word;
   logic             tx_grant;
   logic [N-1:0]     send_to;
   logic             send_en;
   logic [BADDR-1:0] send_addr;
   logic [W-1:0]     send_word;
   logic             busy;
   logic             done;

   icn_tx #(.N(N), .W(W), .BADDR(BADDR), .RDLAT(RDLAT)) dut (
      .clk          (clk),
      .clr          (clr),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_dest     (cmd_dest),
      .cmd_src_addr (cmd_src_addr),
      .cmd_dst_addr (cmd_dst_addr),
      .cmd_len      (cmd_len),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_word  (mem_rd_word),
      .tx_grant     (tx_grant),
      .send_to      (send_to),
      .send_en      (send_en),
      .send_addr    (send_addr),
      .send_word    (send_word),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] mem_f(input logic [BADDR-1:0] a);
      return W'(a) * W'(3);
   endfunction

   // Local memory: contents are a pure function of address, returned RDLAT cycles later.
   logic [W-1:0] pipe_q [RDLAT];
   always_ff @(posedge clk) begin
      pipe_q[0] <= mem_f(mem_rd_addr);
      for (int i = 1; i < RDLAT; i++) pipe_q[i] <= pipe_q[i-1];
   end
   assign mem_rd_word = pipe_q[RDLAT-1];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Observations of one transfer, cycle numbers relative to the accept cycle.
   int               rd_rel[$];
   logic [BADDR-1:0] rd_addr[$];
   int               sd_rel[$];
   logic [BADDR-1:0] sd_addr[$];
   logic [W-1:0]     sd_word[$];
   logic [N-1:0]     sd_to[$];
   int               done_rel[$];
   int               drop_rel;
   logic             ready_at_drop;
   logic             busy_at1;
   int               max_out;
   logic             timed_out;

   task automatic run_cmd(input logic [N-1:0] dest, input logic [BADDR-1:0] src,
                          input logic [BADDR-1:0] dst, input logic [BADDR-1:0] len,
                          input int st_lo, input int st_hi, input bit rgrant,
                          input int abort_after);
      int rel;
      int limit;
      rd_rel.delete(); rd_addr.delete();
      sd_rel.delete(); sd_addr.delete(); sd_word.delete(); sd_to.delete();
      done_rel.delete();
      drop_rel = -1; ready_at_drop = 1'b0; busy_at1 = 1'b0; max_out = 0; timed_out = 1'b0;
      limit = 100 + 12 * int'(len) + ((st_hi >= st_lo) ? (st_hi - st_lo + 1) : 0);
      chk("ready_before_cmd", cmd_ready, 1);
      cmd_dest = dest; cmd_src_addr = src; cmd_dst_addr = dst; cmd_len = len;
      cmd_valid = 1'b1;
      tx_grant = 1'b1;
      rel = 0;
      forever begin
         @(negedge clk);
         rel++;
         cmd_valid = 1'b0;
         if (mem_rd_en) begin
            rd_rel.push_back(rel);
            rd_addr.push_back(mem_rd_addr);
         end
         if (send_en) begin
            sd_rel.push_back(rel);
            sd_addr.push_back(send_addr);
            sd_word.push_back(send_word);
            sd_to.push_back(send_to);
         end
         if (done) done_rel.push_back(rel);
         if (rel == 1) busy_at1 = busy;
         if (rd_addr.size() - sd_rel.size() > max_out) max_out = rd_addr.size() - sd_rel.size();
         if (abort_after > 0 && sd_rel.size() >= abort_after) break;
         if (!busy) begin
            drop_rel = rel;
            ready_at_drop = cmd_ready;
            break;
         end
         if (rel >= limit) begin
            timed_out = 1'b1;
            break;
         end
         tx_grant = rgrant ? ($urandom_range(0, 99) < 65) : !(rel >= st_lo && rel <= st_hi);
      end
      tx_grant = 1'b1;
   endtask

   // Reference: reads src+i, sends (dst+i, mem[src+i]) to dest, in order, exactly len times.
   task automatic check_xfer(input string nm, input logic [N-1:0] dest,
                             input logic [BADDR-1:0] src, input logic [BADDR-1:0] dst,
                             input logic [BADDR-1:0] len);
      int exp_done;
      logic [BADDR-1:0] ea;
      chk({nm, ".timeout"}, timed_out, 0);
      chk({nm, ".nreads"}, rd_addr.size(), len);
      foreach (rd_addr[i]) begin
         ea = src + BADDR'(i);
         chk({nm, ".rdaddr"}, rd_addr[i], ea);
      end
      chk({nm, ".nsends"}, sd_rel.size(), len);
      foreach (sd_rel[i]) begin
         ea = dst + BADDR'(i);
         chk({nm, ".sdaddr"}, sd_addr[i], ea);
         ea = src + BADDR'(i);
         chk({nm, ".sdword"}, sd_word[i], mem_f(ea));
         chk({nm, ".sdto"}, sd_to[i], dest);
      end
      chk({nm, ".ndone"}, done_rel.size(), 1);
      exp_done = (len == 0) ? 1 : ((sd_rel.size() > 0) ? sd_rel[$] : -1);
      if (done_rel.size() > 0) begin
         chk({nm, ".done_at"}, done_rel[0], exp_done);
         chk({nm, ".busy_drop"}, drop_rel, done_rel[0] + 1);
      end
      chk({nm, ".busy_c1"}, busy_at1, 1);
      chk({nm, ".ready_back"}, ready_at_drop, 1);
      chk({nm, ".credit_ok"}, (max_out > DEPTH), 0);
      $display("xfer %s: len=%0d src=%0h dst=%0h reads=%0d sends=%0d done@%0d maxout=%0d",
               nm, len, src, dst, rd_addr.size(), sd_rel.size(),
               (done_rel.size() > 0) ? done_rel[0] : -1, max_out);
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, ".send_en"}, send_en, 0);
      chk({nm, ".send_to"}, send_to, 0);
      chk({nm, ".send_addr"}, send_addr, 0);
      chk({nm, ".send_word"}, send_word, 0);
      chk({nm, ".mem_rd_en"}, mem_rd_en, 0);
      chk({nm, ".busy"}, busy, 0);
      chk({nm, ".done"}, done, 0);
      chk({nm, ".cmd_ready"}, cmd_ready, 1);
   endtask

   typedef struct {
      string            name;
      logic [N-1:0]     dest;
      logic [BADDR-1:0] src;
      logic [BADDR-1:0] dst;
      logic [BADDR-1:0] len;
      int               first_rd;
      int               first_sd;
      int               done_at;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int exp_sd[4];
      logic [N-1:0]     rdest;
      logic [BADDR-1:0] rsrc;
      logic [BADDR-1:0] rdst;
      logic [BADDR-1:0] rlen;

      vecs[0] = '{"basic", 8'h04, 15'h0010, 15'h0100, 15'd4,  1,  5,  8};
      vecs[1] = '{"wrap",  8'h81, 15'h7FFE, 15'h7FFF, 15'd3,  1,  5,  7};
      vecs[2] = '{"zero",  8'h10, 15'h0123, 15'h0456, 15'd0, -1, -1,  1};
      vecs[3] = '{"one",   8'h01, 15'h0055, 15'h00AA, 15'd1,  1,  5,  5};
      vecs[4] = '{"ten",   8'hFF, 15'h0300, 15'h7FF8, 15'd10, 1,  5, 14};

      clr = 1'b0; cmd_valid = 1'b0; cmd_dest = '0; cmd_src_addr = '0;
      cmd_dst_addr = '0; cmd_len = '0; tx_grant = 1'b1;

      // Asynchronous reset takes effect before any clock edge.
      #3 clr = 1'b1;
      #1;
      chk_idle_outputs("reset");
      chk("reset.mem_rd_addr", mem_rd_addr, 0);
      repeat (3) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);

      foreach (vecs[v]) begin
         run_cmd(vecs[v].dest, vecs[v].src, vecs[v].dst, vecs[v].len, 0, -1, 1'b0, 0);
         check_xfer(vecs[v].name, vecs[v].dest, vecs[v].src, vecs[v].dst, vecs[v].len);
         if (vecs[v].len != 0) begin
            foreach (rd_rel[i]) chk({vecs[v].name, ".rd_cycle"}, rd_rel[i], vecs[v].first_rd + i);
            foreach (sd_rel[i]) chk({vecs[v].name, ".sd_cycle"}, sd_rel[i], vecs[v].first_sd + i);
         end
         if (done_rel.size() > 0) chk({vecs[v].name, ".done_cycle"}, done_rel[0], vecs[v].done_at);
      end

      // Grant low in cycles 6..10: two words leave early, the rest after the stall.
      run_cmd(8'h04, 15'h0010, 15'h0100, 15'd4, 6, 10, 1'b0, 0);
      check_xfer("stall", 8'h04, 15'h0010, 15'h0100, 15'd4);
      exp_sd = '{5, 6, 12, 13};
      foreach (sd_rel[i]) if (i < 4) chk("stall.sd_cycle", sd_rel[i], exp_sd[i]);

      // Reset in the middle of an 8-word transfer, then a fresh 2-word transfer.
      run_cmd(8'h20, 15'h0400, 15'h0500, 15'd8, 0, -1, 1'b0, 2);
      chk("midrst.nsends", sd_rel.size(), 2);
      foreach (sd_word[i]) chk("midrst.sdword", sd_word[i], mem_f(15'h0400 + BADDR'(i)));
      clr = 1'b1;
      #1;
      chk_idle_outputs("midrst");
      repeat (2) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      run_cmd(8'h02, 15'h0200, 15'h0040, 15'd2, 0, -1, 1'b0, 0);
      check_xfer("after_rst", 8'h02, 15'h0200, 15'h0040, 15'd2);
      if (done_rel.size() > 0) chk("after_rst.done_cycle", done_rel[0], 6);

      // Random commands with random grant.
      for (int k = 0; k < 25; k++) begin
         rdest = N'($urandom_range(1, 255));
         rsrc  = BADDR'($urandom);
         rdst  = BADDR'($urandom);
         if (k % 4 == 0) rsrc = 15'h7FF0 + BADDR'($urandom_range(0, 15));
         if (k % 5 == 0) rdst = 15'h7FF8 + BADDR'($urandom_range(0, 7));
         rlen = BADDR'($urandom_range(0, 20));
         run_cmd(rdest, rsrc, rdst, rlen, 0, -1, 1'b1, 0);
         check_xfer($sformatf("rand%0d", k), rdest, rsrc, rdst, rlen);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
